// File: rtl/mips_load_unit.sv
// mips_load_unit
//   Load-data unit between the MEM stage and a fixed-latency synchronous
//   data memory. Accepts one load at a time. Issues the word-aligned read,
//   then selects the byte/halfword lanes, extends the result and returns it
//   over a valid/ready handshake.
//
//   Optional feature macro: MIPS_LOAD_UNIT_UNALIGNED_EN
//     undefined : a misaligned load skips memory and responds with
//                 resp_misaligned=1, resp_data=0 one cycle after accept.
//     defined   : a misaligned load is split into two word reads (addr, addr+4)
//                 and the bytes are merged. resp_misaligned stays 0.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   valid, and the payload with it, stays stable until that edge.
//
//   Ports
//     clk, reset        rising-edge clock, async active-high reset
//     req_valid/ready   load request handshake
//     req_opcode        MIPS load opcode (lb/lbu/lh/lhu/lw, others = raw word)
//     req_addr          byte address
//     mem_rd_en         one-cycle read strobe
//     mem_addr          word-aligned read address
//     mem_rdata         read data, valid MEM_LAT cycles after mem_rd_en
//     resp_valid/ready  result handshake
//     resp_data         extended load result
//     resp_misaligned   address-error flag, qualified by resp_valid
module mips_load_unit #(
   parameter int ADDR_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int BIG_ENDIAN = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [5:0]        req_opcode,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_data,
   output logic              resp_misaligned
);

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LW  = 6'b100011;

   // Wait counter value on the cycle where mem_rdata is valid.
   localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD1   = 3'd1,
      S_WAIT1 = 3'd2,
      S_RD2   = 3'd3,
      S_WAIT2 = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [5:0]        op_q, op_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              mis_q, mis_d;
   logic [31:0]       data_q, data_d;
`ifdef MIPS_LOAD_UNIT_UNALIGNED_EN
   logic [31:0]       w0_q, w0_d;
`endif

   function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
      logic r;
      r = 1'b0;
      if ((op == OP_LH) || (op == OP_LHU)) r = off[0];
      if (op == OP_LW)                     r = (off != 2'b00);
      return r;
   endfunction

   // w0 holds the word at the aligned address, w1 the following word
   // (zero for single-word loads). The pair is shifted so the addressed byte
   // sits in the lowest lane (LE) or the highest lane (BE). After that shift,
   // byte, halfword and word extraction no longer depend on the offset.
   function automatic logic [31:0] format_load(input logic [5:0]  op,
                                               input logic [1:0]  off,
                                               input logic [31:0] w0,
                                               input logic [31:0] w1);
      logic [63:0] pair;
      logic [31:0] s;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      if (BIG_ENDIAN != 0) begin
         pair = {w0, w1} << {off, 3'b000};
         s    = pair[63:32];
         b    = s[31:24];
         h    = s[31:16];
      end else begin
         pair = {w1, w0} >> {off, 3'b000};
         s    = pair[31:0];
         b    = s[7:0];
         h    = s[15:0];
      end
      case (op)
         OP_LB:   r = {{24{b[7]}}, b};
         OP_LBU:  r = {24'h0, b};
         OP_LH:   r = {{16{h[15]}}, h};
         OP_LHU:  r = {16'h0, h};
         OP_LW:   r = s;
         default: r = w0;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      off_d   = off_q;
      addr_d  = addr_q;
      mis_d   = mis_q;
      data_d  = data_q;
`ifdef MIPS_LOAD_UNIT_UNALIGNED_EN
      w0_d    = w0_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d   = req_opcode;
               off_d  = req_addr[1:0];
               addr_d = {req_addr[ADDR_W-1:2], 2'b00};
               mis_d  = is_misaligned(req_opcode, req_addr[1:0]);
               cnt_d  = 2'd0;
`ifdef MIPS_LOAD_UNIT_UNALIGNED_EN
               state_d = S_RD1;
`else
               if (is_misaligned(req_opcode, req_addr[1:0])) begin
                  data_d  = 32'h0;
                  state_d = S_RESP;
               end else begin
                  state_d = S_RD1;
               end
`endif
            end
         end
         S_RD1: begin
            cnt_d   = 2'd0;
            state_d = S_WAIT1;
         end
         S_WAIT1: begin
            if (cnt_q == LAT_LAST) begin
`ifdef MIPS_LOAD_UNIT_UNALIGNED_EN
               if (mis_q) begin
                  w0_d    = mem_rdata;
                  state_d = S_RD2;
               end else begin
                  data_d  = format_load(op_q, off_q, mem_rdata, 32'h0);
                  state_d = S_RESP;
               end
`else
               data_d  = format_load(op_q, off_q, mem_rdata, 32'h0);
               state_d = S_RESP;
`endif
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
`ifdef MIPS_LOAD_UNIT_UNALIGNED_EN
         S_RD2: begin
            cnt_d   = 2'd0;
            state_d = S_WAIT2;
         end
         S_WAIT2: begin
            if (cnt_q == LAT_LAST) begin
               data_d  = format_load(op_q, off_q, w0_q, mem_rdata);
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
`endif
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         op_q    <= 6'd0;
         off_q   <= 2'd0;
         addr_q  <= '0;
         mis_q   <= 1'b0;
         data_q  <= 32'h0;
`ifdef MIPS_LOAD_UNIT_UNALIGNED_EN
         w0_q    <= 32'h0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         mis_q   <= mis_d;
         data_q  <= data_d;
`ifdef MIPS_LOAD_UNIT_UNALIGNED_EN
         w0_q    <= w0_d;
`endif
      end
   end

   assign req_ready  = (state_q == S_IDLE) && !reset;
   assign mem_rd_en  = (state_q == S_RD1) || (state_q == S_RD2);
   // Second word address wraps naturally modulo 2^ADDR_W.
   assign mem_addr   = (state_q == S_RD2) ? (addr_q + ADDR_W'(4)) : addr_q;
   assign resp_valid = (state_q == S_RESP);
   assign resp_data  = resp_valid ? data_q : 32'h0;
`ifdef MIPS_LOAD_UNIT_UNALIGNED_EN
   assign resp_misaligned = 1'b0;
`else
   assign resp_misaligned = resp_valid && mis_q;
`endif

endmodule

// File: tb/tb_mips_load_unit.sv
module tb_mips_load_unit;

   localparam int NDUT = 3;
   localparam int LAT_T [NDUT] = '{1, 2, 3};
   localparam int BE_T  [NDUT] = '{0, 1, 0};
`ifdef MIPS_LOAD_UNIT_UNALIGNED_EN
   localparam bit UNAL = 1'b1;
`else
   localparam bit UNAL = 1'b0;
`endif

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LW  = 6'b100011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid [NDUT];
   logic        req_ready [NDUT];
   logic [5:0]  req_opcode [NDUT];
   logic [31:0] req_addr [NDUT];
   logic        mem_rd_en [NDUT];
   logic [31:0] mem_addr [NDUT];
   logic        resp_valid [NDUT];
   logic        resp_ready [NDUT];
   logic [31:0] resp_data [NDUT];
   logic        resp_misaligned [NDUT];

   int n_cmp = 0;
   int n_fail = 0;

   // Memory contents: explicit words override a fixed hash of the address.
   logic [31:0] mem_ovr [logic [31:0]];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      if (mem_ovr.exists(wa)) return mem_ovr[wa];
      return (wa * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int L = LAT_T[g];
      logic [31:0] pd [4];
      logic        pv [4];
      logic [31:0] rdata;

      always @(posedge clk) begin
         if (rst) begin
            for (int k = 0; k < 4; k++) pv[k] <= 1'b0;
         end else begin
            pv[0] <= mem_rd_en[g];
            pd[0] <= mem_word(mem_addr[g]);
            for (int k = 1; k < 4; k++) begin
               pv[k] <= pv[k-1];
               pd[k] <= pd[k-1];
            end
         end
      end
      // Garbage outside the valid slot exposes sampling on the wrong cycle.
      assign rdata = pv[L-1] ? pd[L-1] : 32'hBAD0_BAD0;

      mips_load_unit #(.ADDR_W(32), .MEM_LAT(L), .BIG_ENDIAN(BE_T[g])) u_dut (
         .clk(clk), .reset(rst),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_opcode(req_opcode[g]), .req_addr(req_addr[g]),
         .mem_rd_en(mem_rd_en[g]), .mem_addr(mem_addr[g]), .mem_rdata(rdata),
         .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
         .resp_data(resp_data[g]), .resp_misaligned(resp_misaligned[g])
      );
   end

   // Reference: gather the addressed bytes one at a time from memory and
   // assemble them in address order.
   function automatic logic [7:0] ref_byte(input logic [31:0] a, input int be);
      logic [31:0] t;
      int sh;
      sh = (be != 0) ? (24 - 8 * int'(a[1:0])) : (8 * int'(a[1:0]));
      t = mem_word(a) >> sh;
      return t[7:0];
   endfunction

   task automatic ref_load(input int i, input logic [5:0] op, input logic [31:0] a,
                           output logic [31:0] d, output logic m, output int lat, output int reads);
      int n;
      logic misal;
      logic [31:0] v;
      logic [7:0] bt;
      n = 0;
      if (op == OP_LB || op == OP_LBU) n = 1;
      if (op == OP_LH || op == OP_LHU) n = 2;
      if (op == OP_LW) n = 4;
      misal = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
      lat = LAT_T[i] + 2;
      reads = 1;
      m = 1'b0;
      if (n == 0) begin
         d = mem_word(a);
      end else if (misal && !UNAL) begin
         d = 32'h0; m = 1'b1; lat = 1; reads = 0;
      end else begin
         if (misal) begin
            lat = 3 + 2 * LAT_T[i];
            reads = 2;
         end
         v = 32'h0;
         for (int j = 0; j < n; j++) begin
            bt = ref_byte(a + 32'(j), BE_T[i]);
            if (BE_T[i] != 0) v = (v << 8) | {24'h0, bt};
            else              v = v | ({24'h0, bt} << (8 * j));
         end
         if (op == OP_LB && v[7])  v = v | 32'hFFFF_FF00;
         if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
         d = v;
      end
   endtask

   // Issue one load on dut i starting just after a negedge, check latency,
   // reads, result and the hold/handshake behaviour. Returns just after a negedge.
   task automatic do_load(input int i, input logic [5:0] op, input logic [31:0] a, input int hold,
                          input logic [31:0] exp_d, input logic exp_m, input int exp_lat,
                          input int exp_reads, input string nm);
      int edges;
      int reads;
      bit got;
      logic [31:0] al;
      logic [31:0] ea;
      logic [31:0] d0;
      al = {a[31:2], 2'b00};
      n_cmp++;
      if (req_ready[i] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready_idle dut%0d: got %b expected 1", nm, i, req_ready[i]);
      end
      req_valid[i] = 1'b1;
      req_opcode[i] = op;
      req_addr[i] = a;
      @(posedge clk);
      edges = 0; reads = 0; got = 0;
      while (!got && edges < 30) begin
         @(negedge clk);
         edges++;
         if (edges == 1) req_valid[i] = 1'b0;
         if (resp_valid[i] === 1'b1) begin
            got = 1;
         end else begin
            if (mem_rd_en[i] === 1'b1) begin
               ea = (reads == 0) ? al : al + 32'd4;
               n_cmp++;
               if (mem_addr[i] !== ea) begin
                  n_fail++;
                  $display("FAIL %s mem_addr dut%0d: got %h expected %h", nm, i, mem_addr[i], ea);
               end
               reads++;
            end
            n_cmp++;
            if (req_ready[i] !== 1'b0) begin
               n_fail++;
               $display("FAIL %s ready_busy dut%0d: got %b expected 0", nm, i, req_ready[i]);
            end
         end
      end
      n_cmp++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s timeout dut%0d: no resp_valid within 30 cycles, expected at %0d", nm, i, exp_lat);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         return;
      end
      if (edges != exp_lat) begin
         n_fail++;
         $display("FAIL %s latency dut%0d: got %0d expected %0d", nm, i, edges, exp_lat);
      end
      n_cmp++;
      if (reads != exp_reads) begin
         n_fail++;
         $display("FAIL %s reads dut%0d: got %0d expected %0d", nm, i, reads, exp_reads);
      end
      n_cmp++;
      if (resp_data[i] !== exp_d) begin
         n_fail++;
         $display("FAIL %s data dut%0d op %h addr %h: got %h expected %h", nm, i, op, a, resp_data[i], exp_d);
      end
      n_cmp++;
      if (resp_misaligned[i] !== exp_m) begin
         n_fail++;
         $display("FAIL %s misaligned dut%0d: got %b expected %b", nm, i, resp_misaligned[i], exp_m);
      end
      n_cmp++;
      if (req_ready[i] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s ready_resp dut%0d: got %b expected 0", nm, i, req_ready[i]);
      end
      d0 = exp_d;
      for (int h = 0; h < hold; h++) begin
         // A competing request while the result is pending must be ignored.
         req_valid[i] = 1'b1;
         req_opcode[i] = OP_LW;
         req_addr[i] = a ^ 32'h0000_0040;
         @(negedge clk);
         n_cmp++;
         if (resp_valid[i] !== 1'b1 || resp_data[i] !== d0 || req_ready[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold dut%0d cyc %0d: valid %b data %h ready %b expected 1 %h 0",
                     nm, i, h, resp_valid[i], resp_data[i], req_ready[i], d0);
         end
      end
      req_valid[i] = 1'b0;
      resp_ready[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready[i] = 1'b0;
      n_cmp++;
      if (resp_valid[i] !== 1'b0 || req_ready[i] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s after_hs dut%0d: valid %b ready %b expected 0 1", nm, i, resp_valid[i], req_ready[i]);
      end
   endtask

   task automatic ref_and_load(input int i, input logic [5:0] op, input logic [31:0] a,
                               input int hold, input string nm);
      logic [31:0] d;
      logic m;
      int lat;
      int reads;
      ref_load(i, op, a, d, m, lat, reads);
      do_load(i, op, a, hold, d, m, lat, reads, nm);
   endtask

   task automatic check_zero_outputs(input int i, input string nm);
      n_cmp++;
      if (req_ready[i] !== 1'b0 || mem_rd_en[i] !== 1'b0 || mem_addr[i] !== 32'h0 ||
          resp_valid[i] !== 1'b0 || resp_data[i] !== 32'h0 || resp_misaligned[i] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s dut%0d: rdy %b rd %b addr %h vld %b data %h mis %b expected all 0",
                  nm, i, req_ready[i], mem_rd_en[i], mem_addr[i], resp_valid[i], resp_data[i],
                  resp_misaligned[i]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NDUT; i++) check_zero_outputs(i, "reset_state");
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_byte_half();
      mem_ovr[32'h1000] = 32'h8012_3456;
      do_load(0, OP_LB,  32'h1003, 0, 32'hFFFF_FF80, 1'b0, 3, 1, "lb_le");
      do_load(0, OP_LBU, 32'h1003, 1, 32'h0000_0080, 1'b0, 3, 1, "lbu_le");
      mem_ovr[32'h2000] = 32'h8001_1234;
      do_load(0, OP_LH,  32'h2002, 0, 32'hFFFF_8001, 1'b0, 3, 1, "lh_le");
      do_load(0, OP_LHU, 32'h2002, 0, 32'h0000_8001, 1'b0, 3, 1, "lhu_le");
      do_load(1, OP_LH,  32'h2002, 0, 32'h0000_1234, 1'b0, 4, 1, "lh_be");
   endtask

   task automatic test_hold();
      mem_ovr[32'h3000] = 32'hDEAD_BEEF;
      do_load(2, OP_LW, 32'h3000, 5, 32'hDEAD_BEEF, 1'b0, 5, 1, "lw_hold");
   endtask

   task automatic test_misaligned();
      mem_ovr[32'h1000] = 32'h4433_2211;
      mem_ovr[32'h1004] = 32'h8877_6655;
      if (UNAL) do_load(0, OP_LW, 32'h1001, 0, 32'h5544_3322, 1'b0, 5, 2, "lw_split");
      else      do_load(0, OP_LW, 32'h1001, 0, 32'h0000_0000, 1'b1, 1, 0, "lw_misal");
      ref_and_load(0, OP_LH, 32'hFFFF_FFFF, 0, "lh_wrap");
      ref_and_load(1, OP_LHU, 32'h0000_1003, 1, "lhu_misal_be");
      mem_ovr[32'h4000] = 32'hCAFE_F00D;
      do_load(0, 6'b000000, 32'h4002, 0, 32'hCAFE_F00D, 1'b0, 3, 1, "raw_op");
   endtask

   task automatic test_reset_mid();
      req_valid[2] = 1'b1;
      req_opcode[2] = OP_LW;
      req_addr[2] = 32'h3000;
      @(posedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_zero_outputs(2, "reset_mid");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if (resp_valid[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_noresp dut2: resp_valid %b expected 0", resp_valid[2]);
         end
      end
      mem_ovr[32'h3000] = 32'h1357_9BDF;
      do_load(2, OP_LW, 32'h3000, 0, 32'h1357_9BDF, 1'b0, 5, 1, "after_reset");
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [7];
      logic [5:0] op;
      logic [31:0] a;
      ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, 6'b100010, 6'b000000};
      for (int i = 0; i < NDUT; i++) begin
         for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 6)];
            case ($urandom_range(0, 3))
               0:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
               1:       a = 32'h0000_1000 + 32'($urandom_range(0, 15));
               default: a = $urandom();
            endcase
            ref_and_load(i, op, a, $urandom_range(0, 2), "random");
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      for (int i = 0; i < NDUT; i++) begin
         req_valid[i] = 1'b0;
         req_opcode[i] = 6'd0;
         req_addr[i] = 32'h0;
         resp_ready[i] = 1'b0;
      end
      @(negedge clk);
      test_reset();
      test_byte_half();
      test_hold();
      test_misaligned();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_load_unit.md
Name: mips_load_unit

Overview:
Parametrised load-data unit between the MEM stage and a fixed-latency synchronous data memory. It accepts one load request at a time and issues the word-aligned read. It then performs byte/halfword lane selection and zero/sign extension for lb, lbu, lh, lhu and lw, and returns the result over a valid/ready handshake. It is the sequential successor to the combinational load-data selector: it adds endianness, configurable memory latency, misalignment detection and optional split unaligned loads.

Parameters:
ADDR_W, 32, byte-address width; data word fixed at 32 bits.
MEM_LAT, 1, memory read latency in cycles (legal 1..4): mem_rdata is valid MEM_LAT cycles after the mem_rd_en cycle.
BIG_ENDIAN, 0, 0 = byte k at mem_rdata[8k+7:8k]; 1 = byte k at mem_rdata[31-8k:24-8k].

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  load request valid
req_ready  out  1  unit can accept request
req_opcode  in  6  MIPS load opcode
req_addr  in  ADDR_W  byte address
mem_rd_en  out  1  one-cycle memory read strobe
mem_addr  out  ADDR_W  word-aligned read address (low 2 bits 0)
mem_rdata  in  32  memory read data
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_data  out  32  extended load result
resp_misaligned  out  1  address-error flag, qualified by resp_valid

Behaviour:
- Reset: state IDLE; req_ready=0 while reset is high. mem_rd_en, mem_addr, resp_valid, resp_data and resp_misaligned are 0. Latency counter is cleared. An in-flight memory access is abandoned and its returning data is ignored.
- States: IDLE, RD1, WAIT1, RD2, WAIT2, RESP. req_ready = (state==IDLE) && !reset.
- Accept on req_valid && req_ready at cycle T. Opcode, addr[1:0] and the aligned address are latched.
- Opcodes: 100000 lb (sign), 100100 lbu (zero), 100001 lh (sign), 100101 lhu (zero), 100011 lw. Any other opcode returns the raw aligned word, never misaligned.
- Misaligned: lh/lhu with addr[0]=1; lw with addr[1:0]!=0. Byte loads are never misaligned.
- Aligned path: RD1 at T+1 drives mem_rd_en=1 for exactly one cycle. WAIT1 counts MEM_LAT cycles and samples mem_rdata on the last one. RESP is entered with resp_valid=1 at T+2+MEM_LAT (T+3 for MEM_LAT=1).
- Lane select: byte = lane addr[1:0]; halfword = lanes addr[1]*2 and addr[1]*2+1, ordered per BIG_ENDIAN (big-endian: lower address is the MS byte). Extension to 32 bits follows the opcode.
- RESP: resp_valid, resp_data and resp_misaligned are held stable until resp_ready=1. Return to IDLE on the next edge, so the earliest next accept is the cycle after the handshake. No request is accepted while resp_valid=1.
- Reset mid-operation: return to IDLE immediately. No response is produced for the aborted request.

Optional Feature:
Macro MIPS_LOAD_UNIT_UNALIGNED_EN.
- Undefined: a misaligned request issues no memory read. Go IDLE -> RESP at T+1 with resp_misaligned=1 and resp_data=0. States RD2/WAIT2 are not built.
- Defined: a misaligned request reads the aligned word W0 (RD1/WAIT1), then W1 at aligned address +4, wrapping modulo 2^ADDR_W (RD2/WAIT2).
  - Little-endian result: low bits of {W1,W0} >> 8*addr[1:0].
  - Big-endian result: high bits of {W0,W1} << 8*addr[1:0].
  - Then extend per opcode. resp_misaligned=0.
  - Response at T+3+2*MEM_LAT.
  - Aligned requests are unaffected.

Test Plan:
- LE, MEM_LAT=1, lb/lbu addr 0x1003, mem word 0x80123456 -> resp_data 0xFFFFFF80 / 0x00000080, resp_valid exactly at T+3, mem_addr 0x1000.
- LE, lh/lhu addr 0x2002, word 0x80011234 -> 0xFFFF8001 / 0x00008001. Repeat with BIG_ENDIAN=1 -> lh 0x00001234.
- MEM_LAT=3, lw addr 0x3000, word 0xDEADBEEF, resp_ready held 0 for 5 cycles -> resp_valid at T+5, data stable until handshake, req_ready=0 throughout.
- lw addr 0x1001, macro undefined -> no mem_rd_en, resp_misaligned=1, resp_data=0 at T+1. Macro defined, LE, 0x1000=0x44332211, 0x1004=0x88776655 -> 0x55443322, two reads, valid at T+5.
- lh addr 0xFFFFFFFF, macro defined, LE -> second read at 0x00000000 (wrap). Unknown opcode 000000 at 0x4002 -> raw word, misaligned=0.
- Assert reset during WAIT1 -> outputs 0 immediately, no response. A new request after release completes normally with correct data.
